mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//   MEM pipeline stage, directly downstream of EXE. Latches the EXE->MEM bus and
//   receives synchronous data-SRAM read data one cycle after EXE issued the address.
//   Aligns, extends or merges load data (lb/lbu/lh/lhu/lw/lwl/lwr) and passes
//   exception, CP0 and ERET info to WB. Drives the MEM forward bus to decode and
//   the exception/eret qualifiers that EXE uses to squash stores and HI/LO writes.
// PARAMETERS
//   ES_TO_MS_BUS_WD  160  EXE->MEM bus width
//   MS_TO_WS_BUS_WD  152  MEM->WB bus width
//   FW_BUS_WD        38   forward bus width {gr_we, dest[4:0], result[31:0]}
// PORTS
//   clk              in   1    clock
//   reset            in   1    synchronous, active-high reset
//   eret_flush       in   1    CP0 flush; kills the instruction held in MEM
//   es_to_ms_valid   in   1    EXE has an instruction for MEM
//   es_to_ms_bus     in   160  [159:128] bvaddr, [127] bd, [126:119] cp0_dest, [118] eret, [117] mtc0, [116] mfc0, [115] excp_valid, [114:110] execode, [109:78] rt_value, [77:71] {wl,wr,w,bu,b,hu,h}, [70] res_from_mem, [69] gr_we, [68:64] dest, [63:32] alu_result, [31:0] pc
//   ms_allowin       out  1    MEM can accept this cycle
//   ws_allowin       in   1    WB can accept this cycle
//   ms_to_ws_valid   out  1    MEM presents an instruction to WB
//   ms_to_ws_bus     out  152  [151:120] bvaddr, [119] bd, [118:111] cp0_dest, [110] eret, [109] mtc0, [108] mfc0, [107] excp_valid, [106:102] execode, [101:70] rt_value, [69] gr_we, [68:64] dest, [63:32] final_result, [31:0] pc
//   ms_to_ds_fw_bus  out  38   forward bus to decode
//   out_ms_valid     out  1    ms_valid register
//   ms_excp_valid    out  1    latched excp_valid of the MEM instruction
//   ms_inst_eret     out  1    latched eret of the MEM instruction
//   data_sram_rdata  in   32   read data, valid only in the first cycle after acceptance
// BEHAVIOUR
//   Reset values: ms_valid=0, bus_r=0, rdata_buf=0, rdata_buf_vld=0. All outputs derived; at reset ms_to_ws_valid=0, fw gr_we=0, ms_allowin=1.
//   ms_ready_go=1. ms_allowin = !ms_valid | (ms_ready_go & ws_allowin).
//   ms_to_ws_valid = ms_valid & ms_ready_go.
//   ms_valid: set to 0 on reset or eret_flush (flush has priority over acceptance); else if ms_allowin, ms_valid <= es_to_ms_valid.
//   bus_r <= es_to_ms_bus when es_to_ms_valid & ms_allowin.
//   First cycle after acceptance = capture cycle. Capture cycle uses data_sram_rdata directly; rdata_buf <= data_sram_rdata and rdata_buf_vld <= 1.
//   Later stall cycles (ws_allowin=0) use rdata_buf. rdata_buf_vld clears on a new acceptance, reset or flush.
//   Effective data: rd = rdata_buf_vld ? rdata_buf : data_sram_rdata.
//   Load align, off = alu_result[1:0]:
//     b/bu: byte rd[8*off+7 -: 8], sign- or zero-extended.
//     h/hu: half rd[16*off[1]+15 -: 16], sign- or zero-extended.
//     w: rd.
//     lwl, off 0..3: {rd[7:0],rt[23:0]} / {rd[15:0],rt[15:0]} / {rd[23:0],rt[7:0]} / rd.
//     lwr, off 0..3: rd / {rt[31:24],rd[31:8]} / {rt[31:16],rd[31:16]} / {rt[31:8],rd[31:24]}.
//   final_result = res_from_mem ? aligned : alu_result.
//   If excp_valid=1, WB receives gr_we=0 and all other fields unchanged.
//   Forward bus: {ms_valid & gr_we & !excp_valid & !mfc0, dest, final_result}. mfc0 is never forwarded from MEM.
//   ms_excp_valid and ms_inst_eret are raw latched bits; EXE qualifies them with out_ms_valid.
//   Simultaneous eret_flush & es_to_ms_valid: flush wins, ms_valid=0 next cycle; bus_r may update (don't-care).
//   Reset mid-stall: everything cleared next cycle; a stale buffer is never used.
// TESTING
//   lw, alu_result=0x100, rdata=0x8899AABB, ws_allowin=1 -> final_result=0x8899AABB, fw gr_we=1 in the same cycle.
//   lb, off=3, rdata=0x80FF_FF7F -> 0xFFFFFF80. lbu, same data -> 0x00000080.
//   lh, off=2, rdata=0x8001_1234 -> 0xFFFF8001. lhu, off=0 -> 0x00001234.
//   lwl off=1, rt=0x11223344, rdata=0xAABBCCDD -> 0xCCDD3344. lwr off=2, same data -> 0x1122AABB.
//   lw accepted, ws_allowin=0 for 3 cycles, rdata changes to 0xDEADBEEF after the capture cycle -> WB still gets the captured value.
//   excp_valid=1 (execode 0x04) with eret_flush next cycle -> ms_to_ws gr_we=0, fw gr_we=0, ms_valid=0 after the flush.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage sitting directly after EXE.
//   Holds one instruction from EXE, picks up the synchronous data-SRAM read
//   data in the cycle after acceptance, and buffers it so that a WB stall
//   cannot lose it. Load results are aligned, extended or merged (lb/lbu/lh/
//   lhu/lw/lwl/lwr). Exception, CP0 and ERET information is passed on to WB.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   eret_flush          kills the instruction held in MEM
//   es_to_ms_valid/bus  instruction from EXE; ms_allowin back-pressures EXE
//   ws_allowin          WB can accept; ms_to_ws_valid/bus go to WB
//   ms_to_ds_fw_bus     {gr_we, dest, result} forwarded to decode
//   out_ms_valid        raw MEM valid bit
//   ms_excp_valid       latched exception bit (EXE qualifies with out_ms_valid)
//   ms_inst_eret        latched eret bit (EXE qualifies with out_ms_valid)
//   data_sram_rdata     SRAM read data, valid only in the capture cycle
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 160,
    parameter int MS_TO_WS_BUS_WD = 152,
    parameter int FW_BUS_WD       = 38
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       eret_flush,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_allowin,
    input  logic                       ws_allowin,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [FW_BUS_WD-1:0]       ms_to_ds_fw_bus,
    output logic                       out_ms_valid,
    output logic                       ms_excp_valid,
    output logic                       ms_inst_eret,
    input  logic [31:0]                data_sram_rdata
);

    logic                       ms_valid_q, ms_valid_d;
    logic [ES_TO_MS_BUS_WD-1:0] bus_q, bus_d;
    logic [31:0]                rdata_buf_q, rdata_buf_d;
    logic                       rdata_buf_vld_q, rdata_buf_vld_d;

    logic ms_ready_go;
    logic accept;

    // Fields of the latched EXE->MEM bus
    logic [31:0] bvaddr, rt_value, alu_result, pc;
    logic        bd, eret, mtc0, mfc0, excp_valid, res_from_mem, gr_we;
    logic [7:0]  cp0_dest;
    logic [4:0]  execode, dest;
    logic        ld_wl, ld_wr, ld_w, ld_bu, ld_b, ld_hu, ld_h;

    assign {bvaddr, bd, cp0_dest, eret, mtc0, mfc0, excp_valid, execode,
            rt_value, ld_wl, ld_wr, ld_w, ld_bu, ld_b, ld_hu, ld_h,
            res_from_mem, gr_we, dest, alu_result, pc} = bus_q;

    assign ms_ready_go    = 1'b1;
    assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid_q && ms_ready_go;
    assign accept         = es_to_ms_valid && ms_allowin;

    // Next-state logic. Flush beats acceptance for the valid bit; the bus
    // register may still take the new value, which is harmless since it is
    // marked invalid.
    always_comb begin
        ms_valid_d      = ms_valid_q;
        bus_d           = bus_q;
        rdata_buf_d     = rdata_buf_q;
        rdata_buf_vld_d = rdata_buf_vld_q;
        if (eret_flush)
            ms_valid_d = 1'b0;
        else if (ms_allowin)
            ms_valid_d = es_to_ms_valid;
        if (accept)
            bus_d = es_to_ms_bus;
        // The SRAM only holds its read data for one cycle; keep a copy taken
        // in the capture cycle for any WB stall that follows.
        if (eret_flush || accept) begin
            rdata_buf_vld_d = 1'b0;
        end else if (ms_valid_q && !rdata_buf_vld_q) begin
            rdata_buf_d     = data_sram_rdata;
            rdata_buf_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_q      <= 1'b0;
            bus_q           <= '0;
            rdata_buf_q     <= 32'h0;
            rdata_buf_vld_q <= 1'b0;
        end else begin
            ms_valid_q      <= ms_valid_d;
            bus_q           <= bus_d;
            rdata_buf_q     <= rdata_buf_d;
            rdata_buf_vld_q <= rdata_buf_vld_d;
        end
    end

    // Load alignment
    logic [31:0] rd;
    logic [1:0]  off;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] aligned;
    logic [31:0] final_result;

    assign rd      = rdata_buf_vld_q ? rdata_buf_q : data_sram_rdata;
    assign off     = alu_result[1:0];
    assign ld_half = off[1] ? rd[31:16] : rd[15:0];

    always_comb begin
        case (off)
            2'd0:    ld_byte = rd[7:0];
            2'd1:    ld_byte = rd[15:8];
            2'd2:    ld_byte = rd[23:16];
            default: ld_byte = rd[31:24];
        endcase
    end

    always_comb begin
        aligned = rd;
        if (ld_b)
            aligned = {{24{ld_byte[7]}}, ld_byte};
        else if (ld_bu)
            aligned = {24'h0, ld_byte};
        else if (ld_h)
            aligned = {{16{ld_half[15]}}, ld_half};
        else if (ld_hu)
            aligned = {16'h0, ld_half};
        else if (ld_wl) begin
            case (off)
                2'd0:    aligned = {rd[7:0],  rt_value[23:0]};
                2'd1:    aligned = {rd[15:0], rt_value[15:0]};
                2'd2:    aligned = {rd[23:0], rt_value[7:0]};
                default: aligned = rd;
            endcase
        end else if (ld_wr) begin
            case (off)
                2'd0:    aligned = rd;
                2'd1:    aligned = {rt_value[31:24], rd[31:8]};
                2'd2:    aligned = {rt_value[31:16], rd[31:16]};
                default: aligned = {rt_value[31:8],  rd[31:24]};
            endcase
        end else if (ld_w)
            aligned = rd;
    end

    assign final_result = res_from_mem ? aligned : alu_result;

    // An excepting instruction must not write the register file.
    assign ms_to_ws_bus = {bvaddr, bd, cp0_dest, eret, mtc0, mfc0, excp_valid,
                           execode, rt_value, gr_we && !excp_valid, dest,
                           final_result, pc};

    // mfc0 data only appears in WB, so it is never forwarded from here.
    assign ms_to_ds_fw_bus = {ms_valid_q && gr_we && !excp_valid && !mfc0,
                              dest, final_result};

    assign out_ms_valid  = ms_valid_q;
    assign ms_excp_valid = excp_valid;
    assign ms_inst_eret  = eret;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    logic         clk = 1'b0;
    logic         reset;
    logic         eret_flush;
    logic         es_to_ms_valid;
    logic [159:0] es_to_ms_bus;
    logic         ms_allowin;
    logic         ws_allowin;
    logic         ms_to_ws_valid;
    logic [151:0] ms_to_ws_bus;
    logic [37:0]  ms_to_ds_fw_bus;
    logic         out_ms_valid;
    logic         ms_excp_valid;
    logic         ms_inst_eret;
    logic [31:0]  data_sram_rdata;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [6:0] F_WL = 7'b1000000, F_WR = 7'b0100000, F_W  = 7'b0010000,
                           F_BU = 7'b0001000, F_B  = 7'b0000100, F_HU = 7'b0000010,
                           F_H  = 7'b0000001, F_N  = 7'b0000000;

    mem_stage dut (
        .clk(clk), .reset(reset), .eret_flush(eret_flush),
        .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
        .ms_allowin(ms_allowin), .ws_allowin(ws_allowin),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
        .ms_to_ds_fw_bus(ms_to_ds_fw_bus), .out_ms_valid(out_ms_valid),
        .ms_excp_valid(ms_excp_valid), .ms_inst_eret(ms_inst_eret),
        .data_sram_rdata(data_sram_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [159:0] mk(input logic [6:0] fl, input logic res_mem,
                                        input logic [31:0] alu, input logic [31:0] rt,
                                        input logic [4:0] dest, input logic excp,
                                        input logic [4:0] code, input logic eret,
                                        input logic mfc0);
        mk = {32'hBADD0000, 1'b0, 8'h00, eret, 1'b0, mfc0, excp, code, rt, fl,
              res_mem, 1'b1, dest, alu, 32'h00400000};
    endfunction

    // Present one instruction; returns #1 after the accepting edge.
    task automatic issue(input logic [159:0] b);
        es_to_ms_bus   = b;
        es_to_ms_valid = 1'b1;
        @(posedge clk); #1;
        es_to_ms_valid = 1'b0;
    endtask

    // Single load with WB ready: check the result in the capture cycle.
    task automatic ld(input string tag, input logic [6:0] fl, input logic [31:0] alu,
                      input logic [31:0] rt, input logic [31:0] rdata,
                      input logic [31:0] exp);
        issue(mk(fl, 1'b1, alu, rt, 5'd3, 1'b0, 5'd0, 1'b0, 1'b0));
        data_sram_rdata = rdata;
        @(negedge clk);
        chk(tag, ms_to_ws_bus[63:32], exp);
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; eret_flush = 1'b0; es_to_ms_valid = 1'b0;
        es_to_ms_bus = '0; ws_allowin = 1'b1; data_sram_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid",   {31'h0, ms_to_ws_valid}, 32'h0);
        chk("rst_fw_we",   {31'h0, ms_to_ds_fw_bus[37]}, 32'h0);
        chk("rst_allowin", {31'h0, ms_allowin}, 32'h1);
        chk("rst_pc",      ms_to_ws_bus[31:0], 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // lw, WB ready: result and forward in the capture cycle
        issue(mk(F_W, 1'b1, 32'h100, 32'h0, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0));
        data_sram_rdata = 32'h8899AABB;
        @(negedge clk);
        chk("lw_res",   ms_to_ws_bus[63:32], 32'h8899AABB);
        chk("lw_valid", {31'h0, ms_to_ws_valid}, 32'h1);
        chk("lw_fw",    {26'h0, ms_to_ds_fw_bus[37:32]}, {26'h0, 1'b1, 5'd7});
        chk("lw_fwres", ms_to_ds_fw_bus[31:0], 32'h8899AABB);
        @(posedge clk); #1;
        chk("lw_drain", {31'h0, out_ms_valid}, 32'h0);

        ld("lb3",   F_B,  32'h3, 32'h0,      32'h80FFFF7F, 32'hFFFFFF80);
        ld("lbu3",  F_BU, 32'h3, 32'h0,      32'h80FFFF7F, 32'h00000080);
        ld("lb0",   F_B,  32'h0, 32'h0,      32'h80FFFF7F, 32'h0000007F);
        ld("lh2",   F_H,  32'h2, 32'h0,      32'h80011234, 32'hFFFF8001);
        ld("lhu0",  F_HU, 32'h0, 32'h0,      32'h80011234, 32'h00001234);
        ld("lwl1",  F_WL, 32'h1, 32'h11223344, 32'hAABBCCDD, 32'hCCDD3344);
        ld("lwl3",  F_WL, 32'h3, 32'h11223344, 32'hAABBCCDD, 32'hAABBCCDD);
        ld("lwr2",  F_WR, 32'h2, 32'h11223344, 32'hAABBCCDD, 32'h1122AABB);
        ld("lwr3",  F_WR, 32'h3, 32'h11223344, 32'hAABBCCDD, 32'h112233AA);

        // Non-load passes the ALU result through
        issue(mk(F_N, 1'b0, 32'h13572468, 32'h0, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0));
        data_sram_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("alu_res", ms_to_ws_bus[63:32], 32'h13572468);
        @(posedge clk); #1;

        // mfc0 is never forwarded, but still writes in WB
        issue(mk(F_N, 1'b0, 32'h0, 32'h0, 5'd9, 1'b0, 5'd0, 1'b0, 1'b1));
        @(negedge clk);
        chk("mfc0_fw", {31'h0, ms_to_ds_fw_bus[37]}, 32'h0);
        chk("mfc0_we", {31'h0, ms_to_ws_bus[69]}, 32'h1);
        @(posedge clk); #1;

        // WB stall: captured data must survive SRAM data changing
        ws_allowin = 1'b0;
        issue(mk(F_W, 1'b1, 32'h200, 32'h0, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0));
        data_sram_rdata = 32'h12345678;
        @(negedge clk);
        chk("stl_cap", ms_to_ws_bus[63:32], 32'h12345678);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            data_sram_rdata = 32'hDEADBEEF;
            @(negedge clk);
            chk("stl_hold", ms_to_ws_bus[63:32], 32'h12345678);
            chk("stl_allowin", {31'h0, ms_allowin}, 32'h0);
        end
        ws_allowin = 1'b1;
        @(negedge clk);
        chk("stl_rel", ms_to_ws_bus[63:32], 32'h12345678);
        @(posedge clk); #1;
        chk("stl_drain", {31'h0, out_ms_valid}, 32'h0);

        // Reset mid-stall, then a fresh load must use live SRAM data
        ws_allowin = 1'b0;
        issue(mk(F_W, 1'b1, 32'h300, 32'h0, 5'd6, 1'b0, 5'd0, 1'b0, 1'b0));
        data_sram_rdata = 32'h0BADF00D;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rstm_valid", {31'h0, out_ms_valid}, 32'h0);
        chk("rstm_res",   ms_to_ws_bus[63:32], 32'h0);
        reset = 1'b0; ws_allowin = 1'b1;
        issue(mk(F_W, 1'b1, 32'h304, 32'h0, 5'd6, 1'b0, 5'd0, 1'b0, 1'b0));
        data_sram_rdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("rstm_new", ms_to_ws_bus[63:32], 32'hCAFEF00D);
        @(posedge clk); #1;

        // Exception held in MEM, then flushed
        ws_allowin = 1'b0;
        issue(mk(F_W, 1'b1, 32'h400, 32'h0, 5'd8, 1'b1, 5'h04, 1'b1, 1'b0));
        @(negedge clk);
        chk("exc_we",    {31'h0, ms_to_ws_bus[69]}, 32'h0);
        chk("exc_code",  {27'h0, ms_to_ws_bus[106:102]}, 32'h4);
        chk("exc_bit",   {31'h0, ms_to_ws_bus[107]}, 32'h1);
        chk("exc_fw",    {31'h0, ms_to_ds_fw_bus[37]}, 32'h0);
        chk("exc_raw",   {30'h0, ms_excp_valid, ms_inst_eret}, 32'h3);
        @(posedge clk); #1;
        eret_flush = 1'b1;
        @(posedge clk); #1;
        eret_flush = 1'b0;
        chk("exc_flush", {31'h0, out_ms_valid}, 32'h0);
        chk("exc_wsv",   {31'h0, ms_to_ws_valid}, 32'h0);

        // Flush coinciding with a new instruction: flush wins
        ws_allowin = 1'b1;
        eret_flush = 1'b1;
        issue(mk(F_N, 1'b0, 32'h1, 32'h0, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0));
        eret_flush = 1'b0;
        chk("flush_acc", {31'h0, out_ms_valid}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got stuck expected finish");
        $fatal(1, "timeout");
    end
endmodule
